mc_controller: RTL and testbench
================================

# mc_controller

Multicycle MIPS control unit. A registered state machine that sequences the shared datapath (one memory for instructions and data, one ALU for PC increment, address and arithmetic) across several cycles per instruction. It replaces the single-cycle main decoder. It adds a memory-ready handshake so that instruction fetch, load and store can stall on slow memory. It drives every datapath mux select and write enable, and generates the gated PC enable from the ALU zero flag.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; forces state FETCH
- op  in  6  instruction opcode from the instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- iord  out  1  memory address select: 0 = PC, 1 = ALU result register
- irwrite  out  1  instruction register load
- pcen  out  1  PC load; equals pcwrite | (branch & zero)
- alusrca  out  1  ALU A select: 0 = PC, 1 = register A
- alusrcb  out  2  ALU B select: 00 = B, 01 = constant 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
- aluop  out  2  00 = add, 01 = subtract, 10 = decode funct
- pcsrc  out  2  00 = ALU result, 01 = ALU result register, 10 = jump target
- memwrite  out  1  memory write strobe
- regwrite  out  1  register file write
- regdst  out  1  write register: 0 = rt, 1 = rd
- memtoreg  out  1  write data: 0 = ALU result register, 1 = data register
- illegal  out  1  one-cycle pulse when an unsupported opcode is decoded

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX. The state register is encoded in 4 bits.
- All outputs are decoded combinationally from state and from mem_ready or zero. Any output not listed for a state is 0.
- FETCH: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00.
  - irwrite=pcwrite=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: alusrca=0, alusrcb=11, aluop=00 (precomputes the branch target). Next state by op:
  - 100011 or 101011 → MEMADR
  - 000000 → RTYPEEX
  - 000100 → BEQEX
  - 001000 → ADDIEX
  - 000010 → JEX
  - anything else → FETCH, with illegal=1 for this cycle
- MEMADR: alusrca=1, alusrcb=10, aluop=00. Goes to MEMRD if op=100011, otherwise MEMWR.
- MEMRD: iord=1. Holds until mem_ready=1, then goes to MEMWB.
- MEMWB: regwrite=1, regdst=0, memtoreg=1. Goes to FETCH.
- MEMWR: iord=1 and memwrite=1 for the whole state. Holds until mem_ready=1, then goes to FETCH.
- RTYPEEX: alusrca=1, alusrcb=00, aluop=10. Goes to RTYPEWB.
- RTYPEWB: regwrite=1, regdst=1, memtoreg=0. Goes to FETCH.
- BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1 (so pcen=zero). Goes to FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00. Goes to ADDIWB.
- ADDIWB: regwrite=1, regdst=0, memtoreg=0. Goes to FETCH.
- JEX: pcsrc=10, pcwrite=1. Goes to FETCH.
- Reset:
  - While reset is high, state is FETCH and irwrite, pcen, memwrite, regwrite and illegal are forced to 0.
  - All other outputs take their FETCH values.
  - Asserting reset mid-instruction abandons that instruction. No register or memory write occurs during or after it.
- Illegal state encodings recover to FETCH on the next edge.

## Timing
- Cycle counts with mem_ready always 1:
  - LW 5
  - SW 4
  - R-type 4
  - ADDI 4
  - BEQ 3
  - J 3
- Each memory-wait cycle adds exactly one cycle: in FETCH, in MEMRD, or in MEMWR.
- The PC, instruction register, register file and memory are all written on the rising edge at the end of the cycle in which their enable is high.
- When mem_ready=1 arrives in FETCH, irwrite and pcen pulse for exactly that one cycle.
- zero is sampled only in BEQEX. It is a don't-care in all other states.

## Configuration
- BNE_EN defined:
  - DECODE also accepts op 000101 and goes to a BNEEX state.
  - BNEEX has the same outputs as BEQEX, except pcen = branch & ~zero.
  - BNE takes 3 cycles.
- BNE_EN undefined: op 000101 is illegal (illegal pulse, return to FETCH).

## Test plan
- Reset, then deassert with mem_ready=1 → FETCH outputs on the first cycle, irwrite=pcen=1. No regwrite or memwrite ever occurs during reset.
- LW (op 100011) with mem_ready held 0 for 2 cycles in FETCH and 3 cycles in MEMRD:
  - Instruction takes 10 cycles.
  - regwrite=1 with memtoreg=1 in the final cycle only.
- SW (op 101011), mem_ready=1 → memwrite=1 in cycle 4 only, iord=1 in that cycle, no regwrite.
- BEQ twice:
  - zero=1 → pcen=1 with pcsrc=01 in cycle 3.
  - zero=0 → pcen=0 in cycle 3, next instruction fetched from PC+4.
- Op 111111 → illegal=1 in the DECODE cycle, FETCH next cycle. With BNE_EN undefined, op 000101 gives the same result.
- Reset pulsed during RTYPEEX → FETCH immediately, no regwrite. A following R-type (op 000000) completes in 4 cycles with regwrite=1, regdst=1 in cycle 4.

Source files
------------

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle MIPS control unit with memory-ready stalls
//
// Purpose: registered state machine sequencing a shared-memory, shared-ALU
// MIPS datapath over several cycles per instruction. Fetch, load and store
// wait on mem_ready; every mux select and write enable is decoded here.
// Optional feature macro: BNE_EN (adds the BNE instruction via BNEEX).
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high, forces FETCH
//   op[5:0]    in   opcode from the instruction register
//   zero       in   ALU zero flag (sampled in branch execute only)
//   mem_ready  in   memory completes the current access this cycle
//   iord       out  memory address select (0 PC, 1 ALU result register)
//   irwrite    out  instruction register load
//   pcen       out  PC load = pcwrite | (branch & zero)
//   alusrca    out  ALU A select (0 PC, 1 register A)
//   alusrcb    out  ALU B select (00 B, 01 4, 10 imm, 11 imm<<2)
//   aluop      out  00 add, 01 subtract, 10 decode funct
//   pcsrc      out  00 ALU result, 01 ALU result register, 10 jump target
//   memwrite   out  memory write strobe
//   regwrite   out  register file write
//   regdst     out  write register (0 rt, 1 rd)
//   memtoreg   out  write data (0 ALU result register, 1 data register)
//   illegal    out  one-cycle pulse on an unsupported opcode in DECODE
module mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       irwrite,
  output logic       pcen,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsrc,
  output logic       memwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11,
    S_BNEEX   = 4'd12
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  state_t state_q, state_d;

  // Ungated versions of the write-type strobes; reset masks them below so
  // nothing in the datapath is written while reset is held.
  logic pcwrite, branch, branch_ne;
  logic irwrite_raw, memwrite_raw, regwrite_raw, illegal_raw;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = S_FETCH;
    iord         = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = 2'b00;
    aluop        = 2'b00;
    pcsrc        = 2'b00;
    regdst       = 1'b0;
    memtoreg     = 1'b0;
    pcwrite      = 1'b0;
    branch       = 1'b0;
    branch_ne    = 1'b0;
    irwrite_raw  = 1'b0;
    memwrite_raw = 1'b0;
    regwrite_raw = 1'b0;
    illegal_raw  = 1'b0;

    case (state_q)
      S_FETCH: begin
        alusrcb     = 2'b01;
        irwrite_raw = mem_ready;
        pcwrite     = mem_ready;
        state_d     = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // ALU computes PC+4 + (imm<<2) here so BEQ has its target ready.
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
`ifdef BNE_EN
          OP_BNE:       state_d = S_BNEEX;
`endif
          default: begin
            state_d     = S_FETCH;
            illegal_raw = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        state_d = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        regwrite_raw = 1'b1;
        memtoreg     = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWR: begin
        iord         = 1'b1;
        memwrite_raw = 1'b1;
        state_d      = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
        state_d = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        regwrite_raw = 1'b1;
        regdst       = 1'b1;
        state_d      = S_FETCH;
      end
      S_BEQEX: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        branch  = 1'b1;
        state_d = S_FETCH;
      end
`ifdef BNE_EN
      S_BNEEX: begin
        alusrca   = 1'b1;
        aluop     = 2'b01;
        pcsrc     = 2'b01;
        branch_ne = 1'b1;
        state_d   = S_FETCH;
      end
`endif
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite_raw = 1'b1;
        state_d      = S_FETCH;
      end
      S_JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset is asynchronous, so the enables are masked combinationally too;
  // otherwise a mid-cycle reset would still show the old strobes until the
  // state register settles.
  assign irwrite  = ~reset & irwrite_raw;
  assign memwrite = ~reset & memwrite_raw;
  assign regwrite = ~reset & regwrite_raw;
  assign illegal  = ~reset & illegal_raw;
  assign pcen     = ~reset & (pcwrite | (branch & zero) | (branch_ne & ~zero));

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - directed self-checking bench for mc_controller
module tb_mc_controller;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic       iord, irwrite, pcen, alusrca, memwrite, regwrite, regdst, memtoreg, illegal;
  logic [1:0] alusrcb, aluop, pcsrc;

  int errors = 0;
  int checks = 0;

  mc_controller dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .zero      (zero),
    .mem_ready (mem_ready),
    .iord      (iord),
    .irwrite   (irwrite),
    .pcen      (pcen),
    .alusrca   (alusrca),
    .alusrcb   (alusrcb),
    .aluop     (aluop),
    .pcsrc     (pcsrc),
    .memwrite  (memwrite),
    .regwrite  (regwrite),
    .regdst    (regdst),
    .memtoreg  (memtoreg),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {iord, irwrite, pcen, alusrca, alusrcb, aluop, pcsrc, memwrite, regwrite, regdst, memtoreg, illegal}
  logic [14:0] outs;
  assign outs = {iord, irwrite, pcen, alusrca, alusrcb, aluop, pcsrc,
                 memwrite, regwrite, regdst, memtoreg, illegal};

  localparam logic [14:0] V_F0   = 15'b0_0_0_0_01_00_00_0_0_0_0_0;
  localparam logic [14:0] V_F1   = 15'b0_1_1_0_01_00_00_0_0_0_0_0;
  localparam logic [14:0] V_DEC  = 15'b0_0_0_0_11_00_00_0_0_0_0_0;
  localparam logic [14:0] V_ILL  = 15'b0_0_0_0_11_00_00_0_0_0_0_1;
  localparam logic [14:0] V_MADR = 15'b0_0_0_1_10_00_00_0_0_0_0_0;
  localparam logic [14:0] V_MRD  = 15'b1_0_0_0_00_00_00_0_0_0_0_0;
  localparam logic [14:0] V_MWB  = 15'b0_0_0_0_00_00_00_0_1_0_1_0;
  localparam logic [14:0] V_MWR  = 15'b1_0_0_0_00_00_00_1_0_0_0_0;
  localparam logic [14:0] V_REX  = 15'b0_0_0_1_00_10_00_0_0_0_0_0;
  localparam logic [14:0] V_RWB  = 15'b0_0_0_0_00_00_00_0_1_1_0_0;
  localparam logic [14:0] V_BRT  = 15'b0_0_1_1_00_01_01_0_0_0_0_0;
  localparam logic [14:0] V_BRN  = 15'b0_0_0_1_00_01_01_0_0_0_0_0;
  localparam logic [14:0] V_AWB  = 15'b0_0_0_0_00_00_00_0_1_0_0_0;
  localparam logic [14:0] V_JEX  = 15'b0_0_1_0_00_00_10_0_0_0_0_0;

  task automatic test_reset();
    logic [14:0] e [4];
    logic        r [4];
    e = '{V_F0, V_F0, V_F1, V_ILL};
    r = '{1'b1, 1'b1, 1'b1, 1'b1};
    op = 6'b111111;
    zero = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_ready = r[i];
      reset = (i < 2);
      @(negedge clk);
      checks++;
      if (outs !== e[i]) begin
        errors++;
        $display("FAIL reset cycle %0d: got %b expected %b", i, outs, e[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lw_stall();
    logic [14:0] e [11];
    logic        r [11];
    e = '{V_F0, V_F0, V_F1, V_DEC, V_MADR, V_MRD, V_MRD, V_MRD, V_MRD, V_MWB, V_F0};
    r = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    op = 6'b100011;
    zero = 1'b1;
    for (int i = 0; i < 11; i++) begin
      mem_ready = r[i];
      @(negedge clk);
      checks++;
      if (outs !== e[i]) begin
        errors++;
        $display("FAIL lw_stall cycle %0d: got %b expected %b", i, outs, e[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sw();
    logic [14:0] e [5];
    e = '{V_F1, V_DEC, V_MADR, V_MWR, V_F0};
    op = 6'b101011;
    zero = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mem_ready = (i < 4);
      @(negedge clk);
      checks++;
      if (outs !== e[i]) begin
        errors++;
        $display("FAIL sw cycle %0d: got %b expected %b", i, outs, e[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch(input logic [5:0] opc, input logic z, input logic [14:0] ex3);
    logic [14:0] e [4];
    e = '{V_F1, V_DEC, ex3, V_F0};
    op = opc;
    zero = z;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i < 3);
      @(negedge clk);
      checks++;
      if (outs !== e[i]) begin
        errors++;
        $display("FAIL branch op=%b zero=%b cycle %0d: got %b expected %b", opc, z, i, outs, e[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_addi_j();
    logic [14:0] e [9];
    logic [5:0]  o [9];
    e = '{V_F1, V_DEC, V_MADR, V_AWB, V_F1, V_DEC, V_JEX, V_F0, V_F0};
    o = '{6'b001000, 6'b001000, 6'b001000, 6'b001000,
          6'b000010, 6'b000010, 6'b000010, 6'b000010, 6'b000010};
    zero = 1'b1;
    for (int i = 0; i < 9; i++) begin
      op = o[i];
      mem_ready = (i < 7);
      @(negedge clk);
      checks++;
      if (outs !== e[i]) begin
        errors++;
        $display("FAIL addi_j cycle %0d: got %b expected %b", i, outs, e[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal(input logic [5:0] opc);
    logic [14:0] e [3];
    e = '{V_F1, V_ILL, V_F0};
    op = opc;
    zero = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_ready = (i < 2);
      @(negedge clk);
      checks++;
      if (outs !== e[i]) begin
        errors++;
        $display("FAIL illegal op=%b cycle %0d: got %b expected %b", opc, i, outs, e[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_rtype();
    logic [14:0] e [5];
    op = 6'b000000;
    zero = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== V_F1) begin
      errors++;
      $display("FAIL rst_mid fetch: got %b expected %b", outs, V_F1);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (outs !== V_DEC) begin
      errors++;
      $display("FAIL rst_mid decode: got %b expected %b", outs, V_DEC);
    end
    @(posedge clk); #1;
    // now in RTYPEEX; reset mid-cycle must drop straight to FETCH
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (outs !== V_F0) begin
      errors++;
      $display("FAIL rst_mid abandon: got %b expected %b", outs, V_F0);
    end
    @(posedge clk); #1;
    checks++;
    if (regwrite !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid regwrite: got %b expected 0", regwrite);
    end
    reset = 1'b0;
    e = '{V_F1, V_DEC, V_REX, V_RWB, V_F0};
    for (int i = 0; i < 5; i++) begin
      mem_ready = (i < 4);
      @(negedge clk);
      checks++;
      if (outs !== e[i]) begin
        errors++;
        $display("FAIL rtype_after cycle %0d: got %b expected %b", i, outs, e[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset = 1'b1;
    op = 6'b0;
    zero = 1'b0;
    mem_ready = 1'b1;
    test_reset();
    test_lw_stall();
    test_sw();
    test_branch(6'b000100, 1'b1, V_BRT);
    test_branch(6'b000100, 1'b0, V_BRN);
    test_addi_j();
    test_illegal(6'b111111);
`ifdef BNE_EN
    test_branch(6'b000101, 1'b1, V_BRN);
    test_branch(6'b000101, 1'b0, V_BRT);
`else
    test_illegal(6'b000101);
`endif
    test_reset_mid_rtype();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
